// File: rtl/saw_note_sequencer_pkg.sv
// saw_note_sequencer_pkg
// Shared definitions for the sawtooth note sequencer:
//   state_e    - sequencer FSM state encoding
//   SCALE_W    - width of the generator Scale value
//   REST_SCALE - scale value meaning "silent entry"
//   END_DUR    - duration value marking end of program
package saw_note_sequencer_pkg;
  localparam int SCALE_W = 6;
  localparam logic [SCALE_W-1:0] REST_SCALE = '0;
  localparam int END_DUR = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_PLAY = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_e;
endpackage

// File: rtl/saw_note_sequencer_if.sv
// saw_note_sequencer_if
// Control/table-load bus and generator-facing outputs of the sequencer.
//   start, stop, loop_en        - playback control from UI logic
//   wr_en, wr_addr, wr_scale,
//   wr_dur                      - table write port
//   scale_out, wave_en          - drive the sawtooth generator
//   step_idx, busy, done        - playback status
// master: control side (drives commands, reads status)
// slave : sequencer side
interface saw_note_sequencer_if #(
  parameter int AW    = 3,
  parameter int DUR_W = 8
);
  import saw_note_sequencer_pkg::*;

  logic                start;
  logic                stop;
  logic                loop_en;
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [SCALE_W-1:0]  wr_scale;
  logic [DUR_W-1:0]    wr_dur;
  logic [SCALE_W-1:0]  scale_out;
  logic                wave_en;
  logic [AW-1:0]       step_idx;
  logic                busy;
  logic                done;

  modport master (
    output start, stop, loop_en, wr_en, wr_addr, wr_scale, wr_dur,
    input  scale_out, wave_en, step_idx, busy, done
  );

  modport slave (
    input  start, stop, loop_en, wr_en, wr_addr, wr_scale, wr_dur,
    output scale_out, wave_en, step_idx, busy, done
  );
endinterface

// File: rtl/saw_note_sequencer_tick_prescaler.sv
// saw_note_sequencer_tick_prescaler
// Free-running divider that counts enabled cycles 0..DIV-1 and raises
// tick_o (combinationally, from the registered count) on the cycle the
// count equals DIV-1. With DIV=1 every enabled cycle is a tick.
//   clk_i, rst_i - clock, asynchronous active-high reset
//   clr_i        - synchronous clear of the count (has priority over en_i)
//   en_i         - count enable
//   tick_o       - one-cycle tick
module saw_note_sequencer_tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/saw_note_sequencer.sv
// saw_note_sequencer
// Plays a table of (scale, duration) entries on the sawtooth generator.
// Each non-marker entry plays for dur*TICK_DIV cycles, followed by GAP_CYC
// silent cycles. A dur of 0 ends the program; reaching the last table
// entry also ends it. loop_en, sampled at end of program, restarts at 0.
//   sysclk - clock
//   reset  - asynchronous active-high reset (clears table and outputs)
//   bus    - control/table port and registered generator outputs
module saw_note_sequencer
  import saw_note_sequencer_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int TICK_DIV = 1024,
  parameter int DUR_W    = 8,
  parameter int GAP_CYC  = 16
) (
  input  logic               sysclk,
  input  logic               reset,
  saw_note_sequencer_if.slave bus
);
  localparam int AW       = $clog2(DEPTH);
  localparam int GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [SCALE_W-1:0] tbl_scale_q [DEPTH];
  logic [DUR_W-1:0]   tbl_dur_q   [DEPTH];

  state_e             state_q, state_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic [DUR_W-1:0]   rem_q, rem_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [SCALE_W-1:0] scale_out_q, scale_out_d;
  logic [AW-1:0]      step_idx_q, step_idx_d;
  logic               wave_en_q, wave_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SCALE_W-1:0] rd_scale;
  logic [DUR_W-1:0]   rd_dur;
  logic               dur_tick, gap_tick;
  logic               adv, eop;

  assign rd_scale = tbl_scale_q[idx_q];
  assign rd_dur   = tbl_dur_q[idx_q];

  // Table: writable in every state; the playing entry is latched at LOAD,
  // so rewriting it only shows up at its next LOAD.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_scale_q[i] <= '0;
        tbl_dur_q[i]   <= '0;
      end
    end else if (bus.wr_en) begin
      tbl_scale_q[bus.wr_addr] <= bus.wr_scale;
      tbl_dur_q[bus.wr_addr]   <= bus.wr_dur;
    end
  end

  saw_note_sequencer_tick_prescaler #(.DIV(TICK_DIV)) u_dur_presc (
    .clk_i  (sysclk),
    .rst_i  (reset),
    .clr_i  (state_q == ST_LOAD),
    .en_i   (state_q == ST_PLAY),
    .tick_o (dur_tick)
  );

  saw_note_sequencer_tick_prescaler #(.DIV(1)) u_gap_presc (
    .clk_i  (sysclk),
    .rst_i  (reset),
    .clr_i  (1'b0),
    .en_i   (state_q == ST_GAP),
    .tick_o (gap_tick)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    scale_d = scale_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    adv     = 1'b0;
    eop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d = ST_LOAD;
          idx_d   = '0;
        end
      end
      ST_LOAD: begin
        if (rd_dur == DUR_W'(END_DUR)) begin
          // An empty program never loops, otherwise loop_en decides.
          if (idx_q == '0) state_d = ST_DONE;
          else             eop = 1'b1;
        end else begin
          scale_d = rd_scale;
          rem_d   = rd_dur;
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (dur_tick) begin
          rem_d = rem_q - DUR_W'(1);
          if (rem_q == DUR_W'(1)) begin
            if (GAP_CYC == 0) begin
              adv = 1'b1;
            end else begin
              state_d = ST_GAP;
              gap_d   = GW'(GAP_LAST);
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_tick) begin
          if (gap_q == '0) adv = 1'b1;
          else             gap_d = gap_q - GW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Advancing past the last entry ends the program without reading a marker.
    if (adv) begin
      if (idx_q == LAST_IDX) begin
        eop = 1'b1;
      end else begin
        idx_d   = idx_q + AW'(1);
        state_d = ST_LOAD;
      end
    end

    if (eop) begin
      if (bus.loop_en) begin
        idx_d   = '0;
        state_d = ST_LOAD;
      end else begin
        state_d = ST_DONE;
      end
    end

    if (bus.stop && (state_q != ST_IDLE)) state_d = ST_IDLE;

    // Outputs are registered, so they are derived from the next state.
    scale_out_d = scale_out_q;
    step_idx_d  = step_idx_q;
    wave_en_d   = 1'b0;
    busy_d      = 1'b1;
    done_d      = 1'b0;
    case (state_d)
      ST_IDLE: begin
        scale_out_d = '0;
        step_idx_d  = '0;
        busy_d      = 1'b0;
      end
      ST_LOAD: step_idx_d = idx_d;
      ST_PLAY: begin
        scale_out_d = scale_d;
        wave_en_d   = (scale_d != REST_SCALE);
      end
      ST_DONE: done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      scale_q     <= '0;
      rem_q       <= '0;
      gap_q       <= '0;
      scale_out_q <= '0;
      step_idx_q  <= '0;
      wave_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      scale_q     <= scale_d;
      rem_q       <= rem_d;
      gap_q       <= gap_d;
      scale_out_q <= scale_out_d;
      step_idx_q  <= step_idx_d;
      wave_en_q   <= wave_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.scale_out = scale_out_q;
  assign bus.step_idx  = step_idx_q;
  assign bus.wave_en   = wave_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_saw_note_sequencer.sv
// tb_saw_note_sequencer
// Self-checking bench for saw_note_sequencer with TICK_DIV=4, GAP_CYC=2,
// DEPTH=8. Each scenario pushes the expected per-cycle output tuple
// {scale_out, wave_en, step_idx, busy, done} to a scoreboard queue, then
// steps the clock, popping and comparing one entry per cycle. Cycle 0 is
// the cycle in which start is held high.
module tb_saw_note_sequencer;
  logic clk;
  logic rst;

  saw_note_sequencer_if #(.AW(3), .DUR_W(8)) bus ();

  saw_note_sequencer #(
    .DEPTH   (8),
    .TICK_DIV(4),
    .DUR_W   (8),
    .GAP_CYC (2)
  ) dut (
    .sysclk(clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] val;
    logic [11:0] mask;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_chk  = 0;

  // Expected tuple; chk=0 leaves scale_out unchecked (LOAD/DONE cycles).
  function automatic void push(int n, int sc, int we, int ix, int bz, int dn, int chk);
    exp_t e;
    e.val  = {6'(sc), 1'(we), 3'(ix), 1'(bz), 1'(dn)};
    e.mask = (chk != 0) ? 12'hfff : 12'h03f;
    for (int i = 0; i < n; i++) sb.push_back(e);
  endfunction

  function automatic logic [11:0] obs_now();
    return {bus.scale_out, bus.wave_en, bus.step_idx, bus.busy, bus.done};
  endfunction

  task automatic write_entry(int a, int s, int d);
    @(negedge clk);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 3'(a);
    bus.wr_scale = 6'(s);
    bus.wr_dur   = 8'(d);
    @(negedge clk);
    bus.wr_en    = 1'b0;
  endtask

  task automatic test_reset();
    int cyc;
    exp_t e;
    logic [11:0] o;
    @(negedge clk);
    o = obs_now();
    n_chk++;
    if (o !== 12'h000) $display("FAIL reset_hold obs=%03h exp=000", o);
    else n_pass++;
    rst = 1'b0;
    write_entry(0, 20, 3);
    push(1, 0, 0, 0, 0, 0, 1);
    push(1, 0, 0, 0, 1, 0, 0);
    push(4, 20, 1, 0, 1, 0, 1);
    cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      o = obs_now(); e = sb.pop_front(); n_chk++;
      if ((o & e.mask) !== (e.val & e.mask))
        $display("FAIL reset_pre cyc=%0d obs=%03h exp=%03h", cyc, o, e.val);
      else n_pass++;
      bus.start = (cyc == 0);
      cyc++;
    end
    #2 rst = 1'b1;
    #1;
    o = obs_now();
    n_chk++;
    if (o !== 12'h000) $display("FAIL reset_async obs=%03h exp=000", o);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    // Cleared table: entry 0 is an end marker, so LOAD then DONE.
    push(1, 0, 0, 0, 0, 0, 1);
    push(1, 0, 0, 0, 1, 0, 0);
    push(1, 0, 0, 0, 1, 1, 0);
    push(2, 0, 0, 0, 0, 0, 1);
    cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      o = obs_now(); e = sb.pop_front(); n_chk++;
      if ((o & e.mask) !== (e.val & e.mask))
        $display("FAIL reset_empty cyc=%0d obs=%03h exp=%03h", cyc, o, e.val);
      else n_pass++;
      bus.start = (cyc == 0);
      cyc++;
    end
  endtask

  task automatic test_program();
    int cyc;
    exp_t e;
    logic [11:0] o;
    write_entry(0, 20, 3);
    write_entry(1, 33, 1);
    write_entry(2, 0, 0);
    bus.loop_en = 1'b0;
    push(1, 0, 0, 0, 0, 0, 1);
    push(1, 0, 0, 0, 1, 0, 0);
    push(12, 20, 1, 0, 1, 0, 1);
    push(2, 20, 0, 0, 1, 0, 1);
    push(1, 0, 0, 1, 1, 0, 0);
    push(4, 33, 1, 1, 1, 0, 1);
    push(2, 33, 0, 1, 1, 0, 1);
    push(1, 0, 0, 2, 1, 0, 0);
    push(1, 0, 0, 2, 1, 1, 0);
    push(2, 0, 0, 0, 0, 0, 1);
    cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      o = obs_now(); e = sb.pop_front(); n_chk++;
      if ((o & e.mask) !== (e.val & e.mask))
        $display("FAIL program cyc=%0d obs=%03h exp=%03h", cyc, o, e.val);
      else n_pass++;
      bus.start = (cyc == 0);
      cyc++;
    end
  endtask

  task automatic test_loop();
    int cyc;
    exp_t e;
    logic [11:0] o;
    bus.loop_en = 1'b1;
    push(1, 0, 0, 0, 0, 0, 1);
    push(1, 0, 0, 0, 1, 0, 0);
    push(12, 20, 1, 0, 1, 0, 1);
    push(2, 20, 0, 0, 1, 0, 1);
    push(1, 0, 0, 1, 1, 0, 0);
    push(4, 33, 1, 1, 1, 0, 1);
    push(2, 33, 0, 1, 1, 0, 1);
    push(1, 0, 0, 2, 1, 0, 0);
    push(1, 0, 0, 0, 1, 0, 0);
    // Entry 0 was rewritten while playing; the replay uses the new scale.
    push(6, 25, 1, 0, 1, 0, 1);
    push(2, 0, 0, 0, 0, 0, 1);
    cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      o = obs_now(); e = sb.pop_front(); n_chk++;
      if ((o & e.mask) !== (e.val & e.mask))
        $display("FAIL loop cyc=%0d obs=%03h exp=%03h", cyc, o, e.val);
      else n_pass++;
      bus.start    = (cyc == 0);
      bus.wr_en    = (cyc == 5);
      bus.wr_addr  = 3'd0;
      bus.wr_scale = 6'd25;
      bus.wr_dur   = 8'd3;
      bus.stop     = (cyc == 30);
      cyc++;
    end
    bus.loop_en = 1'b0;
  endtask

  task automatic test_rest();
    int cyc;
    exp_t e;
    logic [11:0] o;
    write_entry(0, 0, 2);
    write_entry(1, 0, 0);
    push(1, 0, 0, 0, 0, 0, 1);
    push(1, 0, 0, 0, 1, 0, 0);
    push(8, 0, 0, 0, 1, 0, 1);
    push(2, 0, 0, 0, 1, 0, 1);
    push(1, 0, 0, 1, 1, 0, 0);
    push(1, 0, 0, 1, 1, 1, 0);
    push(2, 0, 0, 0, 0, 0, 1);
    cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      o = obs_now(); e = sb.pop_front(); n_chk++;
      if ((o & e.mask) !== (e.val & e.mask))
        $display("FAIL rest cyc=%0d obs=%03h exp=%03h", cyc, o, e.val);
      else n_pass++;
      bus.start = (cyc == 0);
      cyc++;
    end
  endtask

  task automatic test_stop();
    int cyc;
    exp_t e;
    logic [11:0] o;
    write_entry(0, 20, 3);
    push(1, 0, 0, 0, 0, 0, 1);
    push(1, 0, 0, 0, 1, 0, 0);
    push(5, 20, 1, 0, 1, 0, 1);
    push(7, 0, 0, 0, 0, 0, 1);
    cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      o = obs_now(); e = sb.pop_front(); n_chk++;
      if ((o & e.mask) !== (e.val & e.mask))
        $display("FAIL stop cyc=%0d obs=%03h exp=%03h", cyc, o, e.val);
      else n_pass++;
      bus.start = (cyc == 0) || (cyc == 10);
      bus.stop  = (cyc == 6) || (cyc == 10);
      cyc++;
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    exp_t e;
    logic [11:0] o;
    for (int i = 0; i < 8; i++) write_entry(i, 10 + i, 1);
    bus.loop_en = 1'b0;
    push(1, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      push(1, 0, 0, i, 1, 0, 0);
      push(4, 10 + i, 1, i, 1, 0, 1);
      push(2, 10 + i, 0, i, 1, 0, 1);
    end
    push(1, 0, 0, 7, 1, 1, 0);
    push(2, 0, 0, 0, 0, 0, 1);
    cyc = 0;
    while (sb.size() > 0) begin
      @(negedge clk);
      o = obs_now(); e = sb.pop_front(); n_chk++;
      if ((o & e.mask) !== (e.val & e.mask))
        $display("FAIL back_to_back cyc=%0d obs=%03h exp=%03h", cyc, o, e.val);
      else n_pass++;
      // A second start while busy must be ignored.
      bus.start = (cyc == 0) || (cyc == 20);
      cyc++;
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.loop_en  = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_scale = '0;
    bus.wr_dur   = '0;
    test_reset();
    test_program();
    test_loop();
    test_rest();
    test_stop();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/saw_note_sequencer.md
Name: saw_note_sequencer

Overview:
Plays a programmable note sequence on the sawtooth duty generator. Drives its 6-bit Scale and enable inputs from a small table of (scale, duration) entries. Each entry is played for a timed duration, followed by a short silent gap. Sits between the control/UI logic, which loads the table and issues start/stop, and the sawtooth generator, whose duty output feeds the PWM stage.

Parameters:
DEPTH, 8, number of table entries (power of 2, ≥2); AW = clog2(DEPTH)
TICK_DIV, 1024, sysclk cycles per duration tick (≥2)
DUR_W, 8, width of per-entry duration field, in ticks
GAP_CYC, 16, sysclk cycles of silence between entries (0 = no gap state)

Ports:
sysclk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state and outputs
start  in  1  single-cycle request to play the table from entry 0
stop  in  1  abort playback; overrides start
loop_en  in  1  sampled at end of program: 1 = restart from entry 0
wr_en  in  1  table write strobe
wr_addr  in  AW  table entry to write
wr_scale  in  6  scale value; 0 = rest (silent entry)
wr_dur  in  DUR_W  duration in ticks; 0 = end-of-program marker
scale_out  out  6  to generator Scale input
wave_en  out  1  to generator enable input
step_idx  out  AW  entry currently loaded/playing
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on normal program completion

Behaviour:
- Reset (async): state=IDLE; all outputs 0; all table entries cleared to scale=0, dur=0; prescaler=0.
- All outputs are registered.
- Table writes are accepted in every state. A write to the currently playing entry takes effect only at that entry's next LOAD.
- States: IDLE, LOAD, PLAY, GAP, DONE.
- IDLE:
  - wave_en=0, scale_out=0, step_idx=0.
  - start && !stop → LOAD with idx=0.
- LOAD (exactly 1 cycle): reads entry[idx].
  - If dur==0, this is end of program:
    - idx==0 (empty program) → DONE.
    - idx≠0 and loop_en=1 → idx=0, LOAD.
    - Otherwise → DONE.
  - Otherwise: latch scale and dur, clear prescaler → PLAY.
- PLAY:
  - scale_out = latched scale; wave_en = (scale≠0).
  - Prescaler counts 0..TICK_DIV-1; a tick occurs on the cycle it equals TICK_DIV-1.
  - Each tick decrements the remaining duration.
  - On the tick taking it to 0: → GAP, or → advance directly if GAP_CYC==0.
  - PLAY lasts exactly dur×TICK_DIV cycles.
- GAP:
  - wave_en=0; scale_out holds the latched value.
  - Lasts GAP_CYC cycles, then advance.
- Advance:
  - idx==DEPTH-1 is treated as end of program: apply the loop_en rule without a LOAD of a marker.
  - Otherwise idx+1 → LOAD.
- DONE (1 cycle): done=1, wave_en=0 → IDLE.
- stop in any non-IDLE state: next cycle is IDLE, wave_en=0, scale_out=0, no done pulse. stop in IDLE has no effect.
- start while busy is ignored.
- Simultaneous start and stop: stop wins.
- Latency: start sampled at edge n → LOAD at n+1 → wave_en/scale_out valid from edge n+2.
- step_idx is updated on entry to LOAD.
- busy rises with LOAD and falls on entry to IDLE.
- Arithmetic: duration counter is DUR_W bits, prescaler is clog2(TICK_DIV) bits, idx wraps modulo DEPTH only via the advance rule above.

Decomposition:
- Shared package: state encoding constants (IDLE/LOAD/PLAY/GAP/DONE), SCALE_W=6, REST_SCALE=0, END_DUR=0.
- One natural sub-module, tick_prescaler: clear input, enable input, one-cycle tick output at count TICK_DIV-1. Instantiated for duration ticks and reused for the GAP cycle count with a divisor of 1.

Test Plan:
Bench uses TICK_DIV=4, GAP_CYC=2, DEPTH=8.
- Reset mid-PLAY with entry0=(20,3) → all outputs 0 in the same cycle, state IDLE, table cleared (a start then yields done after 2 cycles).
- Program {(20,3),(33,1),(0,0)}, pulse start at cycle 0:
  - wave_en=1 and scale_out=20 over cycles 2–13;
  - gap over 14–15;
  - LOAD at 16, scale_out=33 over 17–20;
  - gap, LOAD, DONE with done=1 at cycle 24, then busy=0.
- Same program with loop_en=1 → after entry1's gap, step_idx returns to 0 and scale_out=20 again; no done pulse.
- Rest entry (0,2) → scale_out=0, wave_en=0 for 8 cycles, busy=1 throughout.
- stop asserted on cycle 5 of PLAY, and start+stop together in IDLE → IDLE next cycle with no done pulse; the simultaneous request never leaves IDLE.
- All 8 entries dur=1, loop_en=0 → last entry (idx 7) plays, then done with no wrap to idx 0.
